// File: rtl/buffer_memory_loader.sv
// rtl/buffer_memory_loader.sv - streams words round-robin into BufferMemory banks via its IO port.
// Optional zero-padding of the last partial row: define BUFFER_LOADER_ZERO_PAD_EN.
module buffer_memory_loader #(
   parameter int depth = 2,
   parameter int A     = 7,
   parameter int W     = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 start,
   input  logic [A-1:0]         baseAddr,
   input  logic [A+depth-1:0]   wordCount,
   input  logic [W-1:0]         inData,
   input  logic                 inValid,
   output logic                 inReady,
   output logic [W-1:0]         ioInput,
   output logic [A-1:0]         address,
   output logic [depth-1:0]     ioBankSelect,
   output logic                 write,
   output logic                 ioSelect,
   output logic                 busy,
   output logic                 done
);
   localparam logic [A+depth-1:0] CNT_ONE  = 1;
   localparam logic [depth-1:0]   BANK_ONE = 1;
   localparam logic [A-1:0]       ROW_ONE  = 1;

   typedef enum logic [1:0] {IDLE, LOAD, PAD, DONE} state_t;

   state_t               state, state_next;
   logic [A-1:0]         row;
   logic [depth-1:0]     bank;
   logic [A+depth-1:0]   count;
   logic [A+depth-1:0]   total;
   logic                 accept;
   logic                 last_word;
   logic                 bank_wrap;

   assign accept    = (state == LOAD) && inValid;
   assign last_word = (count == total - CNT_ONE);
   assign bank_wrap = &bank;

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = (wordCount != '0) ? LOAD : DONE;
         LOAD: begin
            if (accept && last_word) begin
`ifdef BUFFER_LOADER_ZERO_PAD_EN
               state_next = bank_wrap ? DONE : PAD;
`else
               state_next = DONE;
`endif
            end
         end
`ifdef BUFFER_LOADER_ZERO_PAD_EN
         PAD:  if (bank_wrap) state_next = DONE;
`endif
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      inReady  = (state == LOAD);
      busy     = (state != IDLE);
      done     = (state == DONE);
      // The final write lands on the edge entering DONE, so the port stays owned for it.
      ioSelect = (state == LOAD) || (state == PAD) || ((state == DONE) && write);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         row          <= '0;
         bank         <= '0;
         count        <= '0;
         total        <= '0;
         ioInput      <= '0;
         address      <= '0;
         ioBankSelect <= '0;
         write        <= 1'b0;
      end else begin
         write <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  row   <= baseAddr;
                  total <= wordCount;
                  bank  <= '0;
                  count <= '0;
               end
            end
            LOAD: begin
               if (accept) begin
                  ioInput      <= inData;
                  address      <= row;
                  ioBankSelect <= bank;
                  write        <= 1'b1;
                  bank         <= bank + BANK_ONE;
                  count        <= count + CNT_ONE;
                  if (bank_wrap) row <= row + ROW_ONE;
               end
            end
`ifdef BUFFER_LOADER_ZERO_PAD_EN
            PAD: begin
               ioInput      <= '0;
               address      <= row;
               ioBankSelect <= bank;
               write        <= 1'b1;
               bank         <= bank + BANK_ONE;
            end
`endif
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_buffer_memory_loader.sv
// tb/tb_buffer_memory_loader.sv - table-driven self-checking bench for buffer_memory_loader.
module tb_buffer_memory_loader;
   logic        CLK = 1'b0;
   logic        RST;
   logic        start;
   logic [6:0]  baseAddr;
   logic [8:0]  wordCount;
   logic [15:0] inData;
   logic        inValid;
   logic        inReady;
   logic [15:0] ioInput;
   logic [6:0]  address;
   logic [1:0]  ioBankSelect;
   logic        write;
   logic        ioSelect;
   logic        busy;
   logic        done;

   buffer_memory_loader #(.depth(2), .A(7), .W(16)) dut (
      .CLK(CLK), .RST(RST), .start(start), .baseAddr(baseAddr), .wordCount(wordCount),
      .inData(inData), .inValid(inValid), .inReady(inReady), .ioInput(ioInput),
      .address(address), .ioBankSelect(ioBankSelect), .write(write), .ioSelect(ioSelect),
      .busy(busy), .done(done)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int failures = 0;
   int sel_err = 0;
   logic [24:0] wq[$];

   // Every visible write is logged as {row, bank, data}.
   always @(negedge CLK) begin
      if (write) begin
         wq.push_back({address, ioBankSelect, ioInput});
         if (!ioSelect) sel_err++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_load(input string tag, input logic [6:0] base, input logic [8:0] cnt,
                           input logic [15:0] d0, input logic [7:0] vpat, input int plen,
                           input bit mid_start, input logic [6:0] erow0, input logic [6:0] erow1,
                           input int ewrites);
      int idx = 0;
      int p = 0;
      int cyc = 0;
      int late = 0;
      int n = int'(cnt);
      bit got = 1'b0;
      logic wd = 1'b0;
      logic [24:0] exp_q[$];
      wq.delete();
      sel_err = 0;
      @(negedge CLK);
      start = 1'b1; baseAddr = base; wordCount = cnt; inValid = 1'b0;
      @(negedge CLK);
      start = 1'b0; baseAddr = 7'($urandom); wordCount = 9'($urandom);
      while (!got && cyc < 200) begin
         if (done) begin
            got = 1'b1;
            wd = write;
         end else begin
            if (idx == n && inReady) late++;
            inValid  = 1'b0;
            inData   = 16'($urandom);
            start    = mid_start && (cyc == 2);
            baseAddr = 7'd99;
            if (idx < n) begin
               if (inReady && vpat[p % plen]) begin
                  inValid = 1'b1;
                  inData  = d0 + 16'(idx);
                  idx++;
               end
               p++;
            end
            @(negedge CLK);
            cyc++;
         end
      end
      start = 1'b0;
      inValid = 1'b0;
      check({tag, " done_seen"}, 32'(got), 32'd1);
      check({tag, " write_in_done_cycle"}, 32'(wd), 32'(n != 0));
      @(negedge CLK);
      check({tag, " idle_after_done"}, {28'd0, done, busy, ioSelect, write}, 32'd0);
      check({tag, " ready_after_last"}, 32'(late), 32'd0);
      check({tag, " ioselect_on_write"}, 32'(sel_err), 32'd0);
      for (int i = 0; i < n; i++)
         exp_q.push_back({7'(int'(base) + (i >> 2)), 2'(i), 16'(d0 + 16'(i))});
`ifdef BUFFER_LOADER_ZERO_PAD_EN
      if (n % 4 != 0)
         for (int b = n % 4; b < 4; b++)
            exp_q.push_back({7'(int'(base) + ((n - 1) >> 2)), 2'(b), 16'h0});
`endif
      check({tag, " write_count"}, 32'(wq.size()), 32'(ewrites));
      if (wq.size() > 0) begin
         check({tag, " first_row"}, 32'(wq[0][24:18]), 32'(erow0));
         check({tag, " last_row"}, 32'(wq[wq.size()-1][24:18]), 32'(erow1));
      end
      for (int i = 0; i < wq.size() && i < exp_q.size(); i++)
         check($sformatf("%s write%0d", tag, i), 32'(wq[i]), 32'(exp_q[i]));
   endtask

   typedef struct {
      logic [6:0]  base;
      logic [8:0]  cnt;
      logic [15:0] d0;
      logic [7:0]  vpat;
      int          plen;
      bit          mid;
      logic [6:0]  r0;
      logic [6:0]  r1;
      int          nw;
   } vec_t;

   vec_t tbl[5];

   initial begin
      tbl[0] = '{7'd5,   9'd8, 16'h1000, 8'hFF,        1, 1'b0, 7'd5,   7'd6,  8};
`ifdef BUFFER_LOADER_ZERO_PAD_EN
      tbl[1] = '{7'd5,   9'd6, 16'h1100, 8'hFF,        1, 1'b0, 7'd5,   7'd6,  8};
      tbl[3] = '{7'd10,  9'd6, 16'h3000, 8'b0010_1101, 6, 1'b1, 7'd10,  7'd11, 8};
`else
      tbl[1] = '{7'd5,   9'd6, 16'h1100, 8'hFF,        1, 1'b0, 7'd5,   7'd6,  6};
      tbl[3] = '{7'd10,  9'd6, 16'h3000, 8'b0010_1101, 6, 1'b1, 7'd10,  7'd11, 6};
`endif
      tbl[2] = '{7'd127, 9'd8, 16'h2000, 8'hFF,        1, 1'b0, 7'd127, 7'd0,  8};
      tbl[4] = '{7'd3,   9'd0, 16'h4000, 8'hFF,        1, 1'b0, 7'd0,   7'd0,  0};

      RST = 1'b1;
      for (int i = 0; i < 3; i++) begin
         start = 1'($urandom); baseAddr = 7'($urandom); wordCount = 9'($urandom);
         inData = 16'($urandom); inValid = 1'($urandom);
         @(negedge CLK);
      end
      check("rst inReady", 32'(inReady), 32'd0);
      check("rst ioInput", 32'(ioInput), 32'd0);
      check("rst address", 32'(address), 32'd0);
      check("rst ioBankSelect", 32'(ioBankSelect), 32'd0);
      check("rst write", 32'(write), 32'd0);
      check("rst ioSelect", 32'(ioSelect), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      RST = 1'b0; start = 1'b0; inValid = 1'b0;

      for (int i = 0; i < 5; i++)
         run_load($sformatf("vec%0d", i), tbl[i].base, tbl[i].cnt, tbl[i].d0, tbl[i].vpat,
                  tbl[i].plen, tbl[i].mid, tbl[i].r0, tbl[i].r1, tbl[i].nw);

      // Abort after three accepted words, then restart from row 0.
      @(negedge CLK);
      start = 1'b1; baseAddr = 7'd20; wordCount = 9'd8;
      @(negedge CLK);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         inValid = 1'b1; inData = 16'h5000 + 16'(i);
         @(negedge CLK);
      end
      RST = 1'b1; inValid = 1'b0;
      @(negedge CLK);
      check("abort outputs", {8'd0, inReady, ioInput, address, ioBankSelect, write, ioSelect, busy, done},
            32'd0);
      RST = 1'b0;
      run_load("restart", 7'd0, 9'd4, 16'h6000, 8'hFF, 1, 1'b0, 7'd0, 7'd0, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/buffer_memory_loader.md
# buffer_memory_loader

Upstream loader for `BufferMemory`. It accepts a start command and a valid/ready stream of W-bit words, and fills `BufferMemory` through its single-bank IO port. Words go round-robin across the D = 2^depth banks, and the row address advances after every D words. It owns the IO-side control signals (`ioSelect`, `write`, `ioBankSelect`, `address`, `ioInput`) while a load is in progress.

## Interface
Parameters:
- `depth`, 2, log2 of bank count; D = 1<<depth
- `A`, 7, row address width of `BufferMemory`
- `W`, 16, data word width

Ports:
- `CLK`  in  1  clock; all logic on rising edge
- `RST`  in  1  reset, synchronous, active-high
- `start`  in  1  begin a load; sampled only in IDLE
- `baseAddr`  in  A  first row address; captured on accepted `start`
- `wordCount`  in  A+depth  number of words to load; captured on accepted `start`
- `inData`  in  W  stream data
- `inValid`  in  1  stream data valid
- `inReady`  out  1  loader can accept a word this cycle
- `ioInput`  out  W  write data to `BufferMemory`
- `address`  out  A  row address to `BufferMemory`
- `ioBankSelect`  out  depth  target bank
- `write`  out  1  write strobe to `BufferMemory`
- `ioSelect`  out  1  IO port owns the memory
- `busy`  out  1  load in progress
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, LOAD, PAD, DONE.
- **IDLE**
  - `start`=1 captures `baseAddr` and `wordCount`, and clears the bank pointer and word counter.
  - Next state is LOAD if `wordCount`≠0, otherwise DONE.
- **LOAD**
  - `inReady`=1.
  - A word is accepted on an edge where `inValid`&&`inReady`.
  - On acceptance, the registered outputs are loaded: `ioInput`=`inData`, `address`=current row, `ioBankSelect`=bank pointer, `write`=1.
  - The bank pointer then increments mod D. When it wraps from D-1 to 0, the row increments mod 2^A (127 wraps to 0).
  - On an edge with no acceptance, `write`=0 and the other data outputs hold.
  - On acceptance of the final word (counter reaches `wordCount`):
    - next state is PAD if the macro is enabled and the post-increment bank pointer ≠ 0;
    - otherwise next state is DONE.
- **PAD** (macro only)
  - `inReady`=0.
  - Each cycle writes `ioInput`=0 to the next bank of the same row, with `write`=1.
  - Moves to DONE after bank D-1 is written.
- **DONE**
  - `done`=1 for exactly one cycle; `inReady`=0.
  - `write` is 0 in this cycle except for the final registered write, which lands on the entry edge.
  - Next state is IDLE.
- Output flags by state:
  - `busy`=1 in LOAD, PAD and DONE.
  - `ioSelect`=1 in LOAD and PAD and during the cycle carrying the final write; otherwise 0.
- `start` while not in IDLE is ignored.
- `inData` is ignored whenever `inReady`=0.
- Word order is preserved exactly; no word is dropped or duplicated.
- `RST` mid-operation aborts immediately:
  - state returns to IDLE;
  - the partial row is left unpadded;
  - all outputs take their reset values on the next cycle.

## Timing
- Reset values: all outputs 0 (`inReady`, `ioInput`, `address`, `ioBankSelect`, `write`, `ioSelect`, `busy`, `done`).
- `start` sampled at edge k → LOAD during cycle after k; `inReady`=1 from that cycle.
- Word accepted at edge n → `write`/`ioInput`/`address`/`ioBankSelect` valid during cycle n..n+1 (1-cycle latency). `BufferMemory` samples them at edge n+1.
- Throughput: 1 word/cycle with continuous `inValid`.
- `done` is high during the cycle after the edge that registered the last write, pad or data.
- `wordCount`=0: `done` is high in the cycle after the start edge, with no writes.

## Configuration
- `BUFFER_LOADER_ZERO_PAD_EN`:
  - **Defined:** when `wordCount` is not a multiple of D, the remaining banks of the last row are zero-filled via the PAD state, so every touched row is fully defined.
  - **Undefined:** the PAD state is absent, the loader goes straight from final word to DONE, and the remaining banks of the last row keep their prior contents.

## Test plan
Defaults depth=2, A=7, W=16.
- **Reset:** hold `RST` 3 cycles with random inputs → all outputs 0, `inReady`=0.
- **Full rows:** `baseAddr`=5, `wordCount`=8, continuous `inData`=0x1000..0x1007 → writes (5,b0..b3)=0x1000..0x1003, then (6,b0..b3)=0x1004..0x1007; `done` for one cycle after the last write; `busy` then 0.
- **Partial row:** `baseAddr`=5, `wordCount`=6:
  - with `BUFFER_LOADER_ZERO_PAD_EN` → additional writes of 0 to (6,b2),(6,b3), `inReady`=0 during pad;
  - without the macro → exactly 6 writes.
- **Wrap:** `baseAddr`=127, `wordCount`=8 → first row 127, second row 0.
- **Backpressure/gaps:** `inValid` pattern 1,0,1,1,0,1 → `write` asserted only the cycle after each acceptance, data in order; `start` pulsed mid-load is ignored.
- **Abort and zero count:**
  - `RST` after 3 accepted words → next cycle all outputs 0; a new `start` with `baseAddr`=0 begins at bank 0.
  - `wordCount`=0 → `done` high on the cycle after start, no `write`.
